// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arbiter_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } arb_state_e;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_LIM = 4;
    localparam int DEF_CNT_W      = 3;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core has fixed priority, DMA gets a
// forced slot after STARVE_LIM consecutive denials.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_LIM = DEF_STARVE_LIM,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STARVE_LIM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIM);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

    // Grants are masked during reset so nothing touches memory while held.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst_n) begin
            if (state_q == ST_FORCE) begin
                dma_gnt  = dma_req;
                core_gnt = core_req && !dma_req;
            end else begin
                core_gnt = core_req;
                dma_gnt  = dma_req && !core_req;
            end
        end
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_read  = !core_we;
            mem_write = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (dma_gnt) begin
            mem_read  = !dma_we;
            mem_write = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign core_stall = core_req && !core_gnt;
    assign core_rdata = (core_gnt && !core_we) ? mem_rdata : '0;
    assign dma_rvalid = dma_rvalid_q;
    assign dma_rdata  = dma_rdata_q;

    // A FORCE slot always lasts exactly one cycle and leaves the counter clear.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        dma_rvalid_d = dma_gnt && !dma_we;
        dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
        if (state_q == ST_FORCE) begin
            state_d      = ST_NORMAL;
            starve_cnt_d = '0;
        end else if (dma_req && !dma_gnt) begin
            if (starve_cnt_q == CNT_TRIG) begin
                state_d = ST_FORCE;
            end
            if (starve_cnt_q != CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_NORMAL;
            starve_cnt_q <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous-write memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
    logic        core_gnt, core_stall, dma_gnt, dma_rvalid;
    logic [31:0] core_rdata, dma_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        c_req;
        logic        c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_cgnt;
        logic        e_cstall;
        logic [31:0] e_crdata;
        logic        e_dgnt;
        logic        e_rvalid;
        logic [31:0] e_drdata;
        logic        e_mrd;
        logic        e_mwr;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_inputs(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic apply_stimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                                  input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        set_inputs(cr, cw, ca, cd, dr, dw, da, dd);
        #1;
    endtask

    // Core load @0x10 and DMA read @0x20 held together; expect DMA only where dma_exp is set.
    task automatic contend(input string tag, input logic dma_exp);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check({tag, " core_gnt"}, 32'(core_gnt), 32'(!dma_exp));
        check({tag, " dma_gnt"}, 32'(dma_gnt), 32'(dma_exp));
        check({tag, " core_stall"}, 32'(core_stall), 32'(dma_exp));
        check({tag, " mem_addr"}, mem_addr, dma_exp ? 32'h20 : 32'h10);
    endtask

    initial begin
        vecs[0]  = '{1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'h0,       1'b0,1'b0,32'h0,        1'b0,1'b1,32'h10,32'hDEADBEEF};
        vecs[1]  = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0,32'h0,        1'b1,1'b0,32'h10,32'h0};
        vecs[2]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h10,32'h0,       1'b0,1'b0,32'h0,       1'b1,1'b0,32'h0,        1'b1,1'b0,32'h10,32'h0};
        vecs[3]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,32'h0,       1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0};
        vecs[4]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b1,32'h20,32'h12345678,1'b0,1'b0,32'h0,       1'b1,1'b0,32'hDEADBEEF, 1'b0,1'b1,32'h20,32'h12345678};
        vecs[5]  = '{1'b1,1'b0,32'h20,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'h12345678,1'b0,1'b0,32'hDEADBEEF, 1'b1,1'b0,32'h20,32'h0};
        vecs[6]  = '{1'b1,1'b1,32'h20,32'hA5A5A5A5, 1'b1,1'b0,32'h20,32'h0,       1'b1,1'b0,32'h0,       1'b0,1'b0,32'hDEADBEEF, 1'b0,1'b1,32'h20,32'hA5A5A5A5};
        vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,         1'b1,1'b0,32'h20,32'h0,       1'b0,1'b0,32'h0,       1'b1,1'b0,32'hDEADBEEF, 1'b1,1'b0,32'h20,32'h0};
        vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,         1'b0,1'b0,32'h0,32'h0,        1'b0,1'b0,32'h0,       1'b0,1'b1,32'hA5A5A5A5, 1'b0,1'b0,32'h0,32'h0};
        vecs[9]  = '{1'b1,1'b1,32'h10,32'h0BADF00D, 1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'h0,       1'b0,1'b0,32'hA5A5A5A5, 1'b0,1'b1,32'h10,32'h0BADF00D};
        vecs[10] = '{1'b1,1'b0,32'h10,32'h0,        1'b0,1'b0,32'h0,32'h0,        1'b1,1'b0,32'h0BADF00D,1'b0,1'b0,32'hA5A5A5A5, 1'b1,1'b0,32'h10,32'h0};

        // Reset with DMA requesting and the core idle.
        rst_n = 1'b0;
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst dma_rvalid", 32'(dma_rvalid), 32'h0);
        check("rst dma_rdata", dma_rdata, 32'h0);
        check("rst dma_gnt", 32'(dma_gnt), 32'h0);
        check("rst core_gnt", 32'(core_gnt), 32'h0);
        check("rst mem_read", 32'(mem_read), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dma_req = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].c_req, vecs[i].c_we, vecs[i].c_addr, vecs[i].c_wdata,
                           vecs[i].d_req, vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata);
            check($sformatf("v%0d core_gnt", i), 32'(core_gnt), 32'(vecs[i].e_cgnt));
            check($sformatf("v%0d core_stall", i), 32'(core_stall), 32'(vecs[i].e_cstall));
            check($sformatf("v%0d core_rdata", i), core_rdata, vecs[i].e_crdata);
            check($sformatf("v%0d dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].e_dgnt));
            check($sformatf("v%0d dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].e_rvalid));
            check($sformatf("v%0d dma_rdata", i), dma_rdata, vecs[i].e_drdata);
            check($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(vecs[i].e_mrd));
            check($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].e_mwr));
            check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
        end

        // Sustained contention: four core grants then one forced DMA slot, twice.
        for (int k = 0; k < 10; k++) begin
            contend($sformatf("cont%0d", k), (k % 5) == 4);
            check($sformatf("cont%0d dma_rvalid", k), 32'(dma_rvalid), 32'(k == 5));
            if (k == 5) check("cont5 dma_rdata", dma_rdata, 32'hA5A5A5A5);
            if (k != 4 && k != 9) check($sformatf("cont%0d core_rdata", k), core_rdata, 32'h0BADF00D);
        end

        // DMA withdraws in its forced slot; the core goes through and the count restarts.
        for (int k = 0; k < 4; k++) contend($sformatf("wd%0d", k), 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h20, 32'h0);
        check("wd force core_gnt", 32'(core_gnt), 32'h1);
        check("wd force core_stall", 32'(core_stall), 32'h0);
        check("wd force dma_gnt", 32'(dma_gnt), 32'h0);
        for (int k = 0; k < 5; k++) contend($sformatf("wd_after%0d", k), k == 4);

        // Async reset the cycle after a DMA read grant.
        apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("rd6 dma_gnt", 32'(dma_gnt), 32'h1);
        @(posedge clk);
        #1;
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd6 dma_rvalid before rst", 32'(dma_rvalid), 32'h1);
        check("rd6 dma_rdata before rst", dma_rdata, 32'hA5A5A5A5);
        #1;
        rst_n = 1'b0;
        #1;
        check("rd6 dma_rvalid in rst", 32'(dma_rvalid), 32'h0);
        check("rd6 dma_rdata in rst", dma_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while a forced slot is pending discards it.
        for (int k = 0; k < 4; k++) contend($sformatf("pend%0d", k), 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("pend rst dma_gnt", 32'(dma_gnt), 32'h0);
        check("pend rst core_gnt", 32'(core_gnt), 32'h0);
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) contend($sformatf("post_rst%0d", k), k == 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
